scene_sequencer: RTL

SCENE_SEQUENCER -- requirements
Module: scene_sequencer

---
 rtl/scene_sequencer_pkg.sv | 25 ++
 rtl/scene_sequencer_if.sv | 25 ++
 rtl/scene_sequencer_dwell_timer.sv | 30 +++
 rtl/scene_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/scene_sequencer_pkg.sv
// Shared types and constants for the LED-matrix scene sequencer.
package scene_sequencer_pkg;

  typedef enum logic [1:0] {
    SCN_SUN   = 2'd0,
    SCN_MOON  = 2'd1,
    SCN_CYCLE = 2'd2,
    SCN_BLANK = 2'd3
  } scene_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [4:0] LAST_SUNMOON = 5'd15;
  localparam logic [4:0] LAST_CYCLE   = 5'd31;

  function automatic logic [4:0] last_frame(input scene_t s);
    return (s == SCN_CYCLE) ? LAST_CYCLE : LAST_SUNMOON;
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Command handshake from the requester plus the display-control outputs.
interface scene_sequencer_if #(
  parameter int DWELL_W = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_scene;
  logic [DWELL_W-1:0] req_dwell;
  logic               req_loop;
  logic [1:0]         scene;
  logic [4:0]         frame_idx;
  logic               blank;
  logic               step_pulse;
  logic               done_pulse;

  modport master (
    output req_valid, req_scene, req_dwell, req_loop,
    input  req_ready, scene, frame_idx, blank, step_pulse, done_pulse
  );

  modport slave (
    input  req_valid, req_scene, req_dwell, req_loop,
    output req_ready, scene, frame_idx, blank, step_pulse, done_pulse
  );
endinterface

// File: rtl/scene_sequencer_dwell_timer.sv
// Counts frame boundaries against the active dwell and strobes when a step is due.
module scene_sequencer_dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               tick,
  input  logic [DWELL_W-1:0] dwell,
  output logic               advance
);

  logic [DWELL_W-1:0] count;
  logic [DWELL_W-1:0] limit;

  // A dwell of zero behaves as one; the limit never exceeds the counter range.
  assign limit   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign advance = tick & (count == limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= advance ? '0 : count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Scene sequencer: accepts scene commands and steps animation frames on frame boundaries.
module scene_sequencer
  import scene_sequencer_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_wrap,
  scene_sequencer_if.slave  bus
);

  state_t             state;
  scene_t             scene_q;
  scene_t             pend_scene;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] pend_dwell;
  logic               loop_q;
  logic               pend_loop;
  logic [4:0]         frame_q;
  logic               blank_q;
  logic               step_q;
  logic               done_q;

  logic ready;
  logic accept;
  logic advance;
  logic timer_clear;
  logic timer_tick;

  assign ready       = (state != ST_SWITCH);
  assign accept      = bus.req_valid & ready;
  assign timer_clear = (state == ST_SWITCH) & scan_wrap;
  // An accept on a boundary pre-empts the step that boundary would have caused.
  assign timer_tick  = (state == ST_RUN) & scan_wrap & ~accept;

  scene_sequencer_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .dwell   (dwell_q),
    .advance (advance)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      scene_q    <= SCN_BLANK;
      pend_scene <= SCN_SUN;
      dwell_q    <= '0;
      pend_dwell <= '0;
      loop_q     <= 1'b0;
      pend_loop  <= 1'b0;
      frame_q    <= '0;
      blank_q    <= 1'b1;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            pend_scene <= scene_t'(bus.req_scene);
            pend_dwell <= bus.req_dwell;
            pend_loop  <= bus.req_loop;
            state      <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          // Swap scenes only at a frame boundary so no frame mixes two scenes.
          if (scan_wrap) begin
            scene_q <= pend_scene;
            dwell_q <= pend_dwell;
            loop_q  <= pend_loop;
            frame_q <= '0;
            step_q  <= (frame_q != 5'd0);
            if (pend_scene == SCN_BLANK) begin
              blank_q <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              blank_q <= 1'b0;
              state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            pend_scene <= scene_t'(bus.req_scene);
            pend_dwell <= bus.req_dwell;
            pend_loop  <= bus.req_loop;
            state      <= ST_SWITCH;
          end else if (advance) begin
            if (frame_q == last_frame(scene_q)) begin
              if (loop_q) begin
                frame_q <= '0;
                step_q  <= 1'b1;
              end else begin
                done_q <= 1'b1;
                state  <= ST_HOLD;
              end
            end else begin
              frame_q <= frame_q + 5'd1;
              step_q  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.scene      = scene_q;
  assign bus.frame_idx  = frame_q;
  assign bus.blank      = blank_q;
  assign bus.step_pulse = step_q;
  assign bus.done_pulse = done_q;

endmodule
